noc_eject_port: RTL and testbench

NOC_EJECT_PORT -- requirements
Module: noc_eject_port

---
 rtl/noc_eject_pkg.sv | 30 +++
 rtl/noc_eject_fifo.sv | 68 ++++++
 rtl/noc_eject_port.sv | 139 +++++++++++++
 tb/tb_noc_eject_port.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_eject_pkg.sv
// Shared constants for the NoC ejection port: flit field offsets, source-id range,
// and the saturating event-counter type and helper.
package noc_eject_pkg;

  localparam int unsigned DX_MSB   = 63;
  localparam int unsigned DX_LSB   = 56;
  localparam int unsigned DY_MSB   = 55;
  localparam int unsigned DY_LSB   = 48;
  localparam int unsigned TYPE_MSB = 47;
  localparam int unsigned TYPE_LSB = 46;
  localparam int unsigned SRC_MSB  = 15;
  localparam int unsigned SRC_LSB  = 12;
  localparam int unsigned SEQ_MSB  = 11;
  localparam int unsigned SEQ_LSB  = 0;

  localparam int unsigned SRC_W = SRC_MSB - SRC_LSB + 1;
  localparam int unsigned SEQ_W = SEQ_MSB - SEQ_LSB + 1;

  localparam int unsigned SRC_ID_MIN = 1;
  localparam int unsigned SRC_ID_MAX = 4;
  localparam int unsigned NUM_SRC    = SRC_ID_MAX - SRC_ID_MIN + 1;

  localparam int unsigned CNT_W = 32;
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t sat_inc(input cnt_t v, input logic en);
    return (en && (v != '1)) ? v + cnt_t'(1) : v;
  endfunction

endpackage

// File: rtl/noc_eject_fifo.sv
// Registered-output FIFO for the ejection port: no bypass, no fall-through,
// pointers wrap modulo DEPTH (DEPTH must be a power of two).
module noc_eject_fifo #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CNT_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [WIDTH-1:0]    push_data,
  input  logic                pop,
  output logic [WIDTH-1:0]    head_data,
  output logic                full,
  output logic                empty,
  output logic [CNT_BITS-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    mem_d [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                do_push, do_pop;

  assign full    = (count_q == CNT_BITS'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  // Storage is not reset; gating on empty keeps the head at zero after reset.
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_BITS'(1);
      2'b01:   count_d = count_q - CNT_BITS'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/noc_eject_port.sv
// NoC ejection port: buffers router flits for the tile, returns credits, keeps event
// counters. Define NOC_EJECT_SEQCHK_EN to compile in per-source sequence checking.
module noc_eject_port
  import noc_eject_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH = 64,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FLIT_WIDTH-1:0] flit_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic                  credit_out,
  output logic [FLIT_WIDTH-1:0] tile_data_out,
  output logic                  tile_valid_out,
  input  logic                  tile_ready_in,
  output logic [4:0]            occupancy,
  output logic [31:0]           flits_rx_count,
  output logic [31:0]           flits_delivered_count,
  output logic [31:0]           backpressure_count,
  output logic [31:0]           misroute_count,
  output logic [31:0]           seq_err_count,
  output logic                  seq_err
);

  logic full, empty, push, pop, misrouted;
  logic credit_q, credit_d;
  cnt_t rx_q, rx_d, dlv_q, dlv_d, bp_q, bp_d, mis_q, mis_d;

  assign ready_out      = !full;
  assign tile_valid_out = !empty;
  assign push           = valid_in && !full;
  assign pop            = !empty && tile_ready_in;
  assign misrouted      = (|flit_in[DX_MSB:DX_LSB]) || (|flit_in[DY_MSB:DY_LSB]);

  noc_eject_fifo #(
    .WIDTH    (FLIT_WIDTH),
    .DEPTH    (DEPTH),
    .CNT_BITS (5)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (flit_in),
    .pop       (pop),
    .head_data (tile_data_out),
    .full      (full),
    .empty     (empty),
    .count     (occupancy)
  );

  always_comb begin
    credit_d = pop;
    rx_d     = sat_inc(rx_q, push);
    dlv_d    = sat_inc(dlv_q, pop);
    bp_d     = sat_inc(bp_q, valid_in && full);
    mis_d    = sat_inc(mis_q, push && misrouted);
  end

  // Reset forces credit low, so a pop coinciding with reset returns no credit.
  always_ff @(posedge clk) begin
    if (reset) begin
      credit_q <= 1'b0;
      rx_q     <= '0;
      dlv_q    <= '0;
      bp_q     <= '0;
      mis_q    <= '0;
    end else begin
      credit_q <= credit_d;
      rx_q     <= rx_d;
      dlv_q    <= dlv_d;
      bp_q     <= bp_d;
      mis_q    <= mis_d;
    end
  end

  assign credit_out            = credit_q;
  assign flits_rx_count        = rx_q;
  assign flits_delivered_count = dlv_q;
  assign backpressure_count    = bp_q;
  assign misroute_count        = mis_q;

`ifdef NOC_EJECT_SEQCHK_EN
  localparam int unsigned SRC_IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] seen_q, seen_d;
  logic [SEQ_W-1:0]   exp_q [NUM_SRC];
  logic [SEQ_W-1:0]   exp_d [NUM_SRC];
  cnt_t               seq_cnt_q, seq_cnt_d;
  logic               seq_err_q, seq_err_d;
  logic [SRC_W-1:0]   src_id;
  logic [SEQ_W-1:0]   seq;
  logic [SRC_IDX_W-1:0] src_idx;

  assign src_id  = flit_in[SRC_MSB:SRC_LSB];
  assign seq     = flit_in[SEQ_MSB:SEQ_LSB];
  assign src_idx = SRC_IDX_W'(src_id - SRC_W'(SRC_ID_MIN));

  // Every tracked flit resyncs expected to seq+1, whether or not it matched.
  always_comb begin
    seen_d    = seen_q;
    exp_d     = exp_q;
    seq_cnt_d = seq_cnt_q;
    seq_err_d = seq_err_q;
    if (push && (src_id >= SRC_W'(SRC_ID_MIN)) && (src_id <= SRC_W'(SRC_ID_MAX))) begin
      if (seen_q[src_idx] && (seq != exp_q[src_idx])) begin
        seq_cnt_d = sat_inc(seq_cnt_q, 1'b1);
        seq_err_d = 1'b1;
      end
      seen_d[src_idx] = 1'b1;
      exp_d[src_idx]  = seq + SEQ_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seen_q    <= '0;
      seq_cnt_q <= '0;
      seq_err_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        exp_q[i] <= '0;
      end
    end else begin
      seen_q    <= seen_d;
      exp_q     <= exp_d;
      seq_cnt_q <= seq_cnt_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign seq_err_count = seq_cnt_q;
  assign seq_err       = seq_err_q;
`else
  assign seq_err_count = '0;
  assign seq_err       = 1'b0;
`endif

endmodule

// File: tb/tb_noc_eject_port.sv
// Scoreboard bench for noc_eject_port: stimulus queues expected flits and status
// values; a negedge monitor compares them and checks credit timing every cycle.
module tb_noc_eject_port;

  localparam int unsigned FW = 64;
  localparam int unsigned D  = 4;

`ifdef NOC_EJECT_SEQCHK_EN
  localparam logic [63:0] EXP_SEQ_ERR = 64'd1;
`else
  localparam logic [63:0] EXP_SEQ_ERR = 64'd0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [FW-1:0] flit_in = '0;
  logic          valid_in = 1'b0;
  logic          tile_ready_in = 1'b0;
  logic          ready_out, credit_out, tile_valid_out, seq_err;
  logic [FW-1:0] tile_data_out;
  logic [4:0]    occupancy;
  logic [31:0]   flits_rx_count, flits_delivered_count, backpressure_count;
  logic [31:0]   misroute_count, seq_err_count;

  always #5 clk = ~clk;

  noc_eject_port #(.FLIT_WIDTH(FW), .DEPTH(D)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .flit_in               (flit_in),
    .valid_in              (valid_in),
    .ready_out             (ready_out),
    .credit_out            (credit_out),
    .tile_data_out         (tile_data_out),
    .tile_valid_out        (tile_valid_out),
    .tile_ready_in         (tile_ready_in),
    .occupancy             (occupancy),
    .flits_rx_count        (flits_rx_count),
    .flits_delivered_count (flits_delivered_count),
    .backpressure_count    (backpressure_count),
    .misroute_count        (misroute_count),
    .seq_err_count         (seq_err_count),
    .seq_err               (seq_err)
  );

  typedef enum int {
    S_OCC, S_READY, S_TVALID, S_DATA, S_RX, S_DLV, S_BP, S_MIS,
    S_SEQCNT, S_SEQERR, S_CREDITS, S_SBLEFT
  } sel_e;

  typedef struct {
    string       name;
    sel_e        sel;
    logic [63:0] want;
  } chk_t;

  chk_t        chk_q[$];
  logic [63:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          credit_seen = 0;
  logic        pop_prev = 1'b0;

  function automatic logic [63:0] sample(input sel_e s);
    case (s)
      S_OCC:     return 64'(occupancy);
      S_READY:   return 64'(ready_out);
      S_TVALID:  return 64'(tile_valid_out);
      S_DATA:    return tile_data_out;
      S_RX:      return 64'(flits_rx_count);
      S_DLV:     return 64'(flits_delivered_count);
      S_BP:      return 64'(backpressure_count);
      S_MIS:     return 64'(misroute_count);
      S_SEQCNT:  return 64'(seq_err_count);
      S_SEQERR:  return 64'(seq_err);
      S_CREDITS: return 64'(credit_seen);
      S_SBLEFT:  return 64'(exp_q.size());
      default:   return '1;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [63:0] act;
    logic [63:0] e;
    chk_t        c;
    checks++;
    if (credit_out !== pop_prev) begin
      errors++;
      $display("FAIL credit_timing: got %0b want %0b at %0t", credit_out, pop_prev, $time);
    end
    if (credit_out === 1'b1) credit_seen++;
    pop_prev = (tile_valid_out === 1'b1) && tile_ready_in && !reset;
    if (pop_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: data %h with empty scoreboard at %0t", tile_data_out, $time);
      end else begin
        e = exp_q.pop_front();
        if (tile_data_out !== e) begin
          errors++;
          $display("FAIL pop_data: got %h want %h at %0t", tile_data_out, e, $time);
        end
      end
    end
    while (chk_q.size() > 0) begin
      c   = chk_q.pop_front();
      act = sample(c.sel);
      checks++;
      if (act !== c.want) begin
        errors++;
        $display("FAIL %s: got %0h want %0h at %0t", c.name, act, c.want, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string n, input sel_e s, input logic [63:0] v);
    chk_t c;
    c.name = n;
    c.sel  = s;
    c.want = v;
    chk_q.push_back(c);
  endtask

  function automatic logic [63:0] mk(input logic [7:0] dx, input logic [7:0] dy,
                                     input logic [15:0] tag);
    return {dx, dy, 2'b01, 14'h0, tag, tag};
  endfunction

  // Leaves valid_in high so consecutive calls stream back-to-back.
  task automatic send(input logic [63:0] f);
    int unsigned waited = 0;
    flit_in  = f;
    valid_in = 1'b1;
    while (ready_out !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) begin
      expect_val("send_timeout_ready", S_READY, 64'd1);
      valid_in = 1'b0;
    end else begin
      exp_q.push_back(f);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    expect_val("rst_occ", S_OCC, 64'd0);
    expect_val("rst_ready", S_READY, 64'd1);
    expect_val("rst_tvalid", S_TVALID, 64'd0);
    expect_val("rst_data", S_DATA, 64'd0);
    expect_val("rst_rx", S_RX, 64'd0);
    expect_val("rst_seqerr", S_SEQERR, 64'd0);

    // Fill with the tile stalled.
    for (int i = 0; i < 4; i++) send(mk(8'h00, 8'h00, 16'h1000 + 16'(i)));
    valid_in = 1'b0;
    expect_val("fill_occ", S_OCC, 64'd4);
    expect_val("fill_ready", S_READY, 64'd0);
    expect_val("fill_rx", S_RX, 64'd4);
    expect_val("fill_credits", S_CREDITS, 64'd0);
    expect_val("fill_tvalid", S_TVALID, 64'd1);

    // Three refused cycles, then drain.
    flit_in  = mk(8'h00, 8'h00, 16'h1FFF);
    valid_in = 1'b1;
    repeat (3) tick();
    valid_in      = 1'b0;
    tile_ready_in = 1'b1;
    repeat (6) tick();
    expect_val("bp_count", S_BP, 64'd3);
    expect_val("drain_dlv", S_DLV, 64'd4);
    expect_val("drain_credits", S_CREDITS, 64'd4);
    expect_val("drain_occ", S_OCC, 64'd0);
    expect_val("drain_tvalid", S_TVALID, 64'd0);

    // Continuous streaming: simultaneous push/pop holds occupancy at 1.
    for (int i = 0; i < 10; i++) begin
      send(mk(8'h00, 8'h00, 16'h3000 + 16'(i)));
      expect_val("stream_occ", S_OCC, 64'd1);
    end
    valid_in = 1'b0;
    repeat (4) tick();
    expect_val("stream_dlv", S_DLV, 64'd14);
    expect_val("stream_credits", S_CREDITS, 64'd14);
    expect_val("stream_occ_end", S_OCC, 64'd0);

    // Misrouted flit is counted and still delivered.
    send(mk(8'h01, 8'h00, 16'h4000));
    valid_in = 1'b0;
    repeat (3) tick();
    expect_val("mis_count", S_MIS, 64'd1);
    expect_val("mis_dlv", S_DLV, 64'd15);

    // Source 2 skips seq 2; sources 5 and 0 are outside the tracked range.
    send(mk(8'h00, 8'h00, 16'h2000));
    send(mk(8'h00, 8'h00, 16'h2001));
    send(mk(8'h00, 8'h00, 16'h2003));
    send(mk(8'h00, 8'h00, 16'h2004));
    send(mk(8'h00, 8'h00, 16'h5007));
    send(mk(8'h00, 8'h00, 16'h0003));
    valid_in = 1'b0;
    repeat (4) tick();
    expect_val("seq_count", S_SEQCNT, EXP_SEQ_ERR);
    expect_val("seq_sticky", S_SEQERR, EXP_SEQ_ERR);
    expect_val("seq_rx", S_RX, 64'd21);
    expect_val("seq_dlv", S_DLV, 64'd21);
    expect_val("seq_credits", S_CREDITS, 64'd21);
    expect_val("seq_mis", S_MIS, 64'd1);

    // Reset with three flits buffered: contents dropped, no credits.
    tile_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) send(mk(8'h00, 8'h00, 16'h0010 + 16'(i)));
    valid_in = 1'b0;
    expect_val("pre_rst_occ", S_OCC, 64'd3);
    tick();
    reset         = 1'b1;
    tile_ready_in = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    expect_val("mid_rst_occ", S_OCC, 64'd0);
    expect_val("mid_rst_tvalid", S_TVALID, 64'd0);
    expect_val("mid_rst_ready", S_READY, 64'd1);
    expect_val("mid_rst_data", S_DATA, 64'd0);
    expect_val("mid_rst_rx", S_RX, 64'd0);
    expect_val("mid_rst_dlv", S_DLV, 64'd0);
    expect_val("mid_rst_bp", S_BP, 64'd0);
    expect_val("mid_rst_mis", S_MIS, 64'd0);
    expect_val("mid_rst_seqcnt", S_SEQCNT, 64'd0);
    expect_val("mid_rst_seqerr", S_SEQERR, 64'd0);
    expect_val("mid_rst_credits", S_CREDITS, 64'd21);
    repeat (2) tick();
    tile_ready_in = 1'b0;
    expect_val("scoreboard_empty", S_SBLEFT, 64'd0);
    expect_val("post_rst_credits", S_CREDITS, 64'd21);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
